// File: rtl/ysyx_22050019_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050019_axi_pkg
// Purpose  : Response codes and FSM state encoding shared by the memory
//            responder and the data cache miss/write-back port.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RWAIT = 3'd1,
    S_R     = 3'd2,
    S_WDATA = 3'd3,
    S_WWAIT = 3'd4,
    S_B     = 3'd5
  } axi_state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050019_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050019_lat_cnt
// Purpose  : 8-bit loadable down-counter that times the response latency of
//            both the read and the write path. done flags the last wait cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050019_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       done
);

  // Load has priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 8'd0;
    end else if (load) begin
      value <= load_value;
    end else if (en && (value != 8'd0)) begin
      value <= value - 8'd1;
    end
  end

  assign done = (value == 8'd1);

endmodule
`default_nettype wire

// File: rtl/ysyx_22050019_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050019_axi_mem_slave
// Purpose  : Single-beat AXI-lite-style memory responder with a word-addressed
//            SRAM array and programmable response latency. One transaction is
//            in flight at a time; a write request wins over a read request.
// Options  : YSYX_22050019_MEM_DECERR_EN - out-of-range addresses answer
//            DECERR (reads return 0, writes are dropped). Without it, addresses
//            alias through index truncation and every response is OKAY.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050019_axi_mem_slave
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [1:0]              r_resp_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [1:0]              b_resp_o
);

  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY);

  axi_state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  idx_err;
  logic [ADDR_WIDTH-1:0] ar_off, aw_off;
  logic [IDX_W-1:0]      ar_idx, aw_idx, rd_idx;
  logic                  ar_err, aw_err, rd_err;
  logic                  ar_hs, aw_hs, w_hs;
  logic                  cnt_load, cnt_en, cnt_done;
  logic [7:0]            cnt_value_unused;
  logic                  unused_addr_bits;

  // Byte offset from the base; bits [2:0] select a byte and are ignored.
  assign ar_off = ar_addr_i - BASE_ADDR;
  assign aw_off = aw_addr_i - BASE_ADDR;
  assign ar_idx = ar_off[IDX_W+2:3];
  assign aw_idx = aw_off[IDX_W+2:3];
  assign unused_addr_bits = ^{ar_off, aw_off};

`ifdef YSYX_22050019_MEM_DECERR_EN
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH) << 3;
  // Addresses below the base wrap to huge offsets, so one compare covers both ends.
  assign ar_err = (ar_off >= SPAN);
  assign aw_err = (aw_off >= SPAN);
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  // Ready signals are forced low in the reset cycle so nothing is accepted.
  assign aw_ready_o = (state == S_IDLE) & ~rst;
  assign ar_ready_o = (state == S_IDLE) & ~aw_valid_i & ~rst;
  assign w_ready_o  = (state == S_WDATA) & ~rst;
  assign r_valid_o  = (state == S_R);
  assign b_valid_o  = (state == S_B);
  assign b_resp_o   = ((state == S_B) && idx_err) ? RESP_DECERR : RESP_OKAY;

  assign ar_hs = ar_valid_i & ar_ready_o;
  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;

  assign cnt_load = ar_hs | w_hs;
  assign cnt_en   = (state == S_RWAIT) | (state == S_WWAIT);

  // With zero latency the index is read straight from the incoming address.
  assign rd_idx = (state == S_IDLE) ? ar_idx : idx;
  assign rd_err = (state == S_IDLE) ? ar_err : idx_err;

  ysyx_22050019_lat_cnt u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (LAT_LOAD),
    .value      (cnt_value_unused),
    .done       (cnt_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; writes take priority over reads in idle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (aw_valid_i) begin
          state_next = S_WDATA;
        end else if (ar_valid_i) begin
          state_next = (LATENCY == 0) ? S_R : S_RWAIT;
        end
      end
      S_RWAIT: if (cnt_done)  state_next = S_R;
      S_R:     if (r_ready_i) state_next = S_IDLE;
      S_WDATA: if (w_valid_i) state_next = (LATENCY == 0) ? S_B : S_WWAIT;
      S_WWAIT: if (cnt_done)  state_next = S_B;
      S_B:     if (b_ready_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the target word index and its range status at the address handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      idx_err <= 1'b0;
    end else if (aw_hs) begin
      idx     <= aw_idx;
      idx_err <= aw_err;
    end else if (ar_hs) begin
      idx     <= ar_idx;
      idx_err <= ar_err;
    end
  end

  // Register read data and response on entry to S_R; held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_o <= '0;
      r_resp_o <= RESP_OKAY;
    end else if ((state != S_R) && (state_next == S_R)) begin
      r_data_o <= rd_err ? '0 : mem[rd_idx];
      r_resp_o <= rd_err ? RESP_DECERR : RESP_OKAY;
    end
  end

  // Commit strobed bytes on the w handshake; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_hs && !idx_err) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (w_strb_i[b]) begin
          mem[idx][b*8 +: 8] <= w_data_i[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050019_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050019_axi_mem_slave
// Purpose  : Directed self-checking bench for the AXI memory responder. A
//            word-array model predicts read data and responses; a monitor
//            compares every valid response cycle against it.
// Options  : YSYX_22050019_MEM_DECERR_EN selects the DECERR scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050019_axi_mem_slave;

  localparam int          DW    = 64;
  localparam int          AW    = 64;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic          clk, rst;
  logic          ar_valid, ar_ready, r_valid, r_ready;
  logic [AW-1:0] ar_addr, aw_addr;
  logic [1:0]    r_resp, b_resp;
  logic [DW-1:0] r_data, w_data;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [7:0]    w_strb;

  ysyx_22050019_axi_mem_slave #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .MEM_DEPTH (DEPTH),
    .BASE_ADDR  (BASE), .LATENCY (LAT)
  ) dut (
    .clk (clk), .rst (rst),
    .ar_valid_i (ar_valid), .ar_ready_o (ar_ready), .ar_addr_i (ar_addr),
    .r_valid_o (r_valid), .r_ready_i (r_ready), .r_resp_o (r_resp), .r_data_o (r_data),
    .aw_valid_i (aw_valid), .aw_ready_o (aw_ready), .aw_addr_i (aw_addr),
    .w_valid_i (w_valid), .w_ready_o (w_ready), .w_strb_i (w_strb), .w_data_i (w_data),
    .b_valid_o (b_valid), .b_ready_i (b_ready), .b_resp_o (b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [63:0] mdl [DEPTH];
  logic [7:0]  mkb [DEPTH];   // per-byte "has been written" flags

  function automatic int unsigned m_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return int'((off >> 3) % 64'(DEPTH));
  endfunction

  function automatic bit m_inrange(input logic [63:0] a);
    return (a - BASE) < 64'(DEPTH * 8);
  endfunction

  function automatic logic [1:0] m_resp(input logic [63:0] a);
`ifdef YSYX_22050019_MEM_DECERR_EN
    return m_inrange(a) ? 2'b00 : 2'b11;
`else
    return (m_inrange(a) || !m_inrange(a)) ? 2'b00 : 2'b11;
`endif
  endfunction

  task automatic m_read(input logic [63:0] a, output logic [63:0] d, output bit known);
    int unsigned i;
    i = m_idx(a);
`ifdef YSYX_22050019_MEM_DECERR_EN
    if (!m_inrange(a)) begin
      d = '0;
      known = 1'b1;
      return;
    end
`endif
    d = mdl[i];
    known = (mkb[i] == 8'hFF);
  endtask

  task automatic m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int unsigned i;
    i = m_idx(a);
`ifdef YSYX_22050019_MEM_DECERR_EN
    if (!m_inrange(a)) return;
`endif
    for (int b = 0; b < 8; b++) begin
      if (s[b]) begin
        mdl[i][b*8 +: 8] = d[b*8 +: 8];
        mkb[i][b] = 1'b1;
      end
    end
  endtask

  // ---------------- expectations for the monitor ----------------
  bit          chk_en, exp_r_pend, exp_b_pend, exp_r_known;
  logic [63:0] exp_r_data;
  logic [1:0]  exp_r_resp, exp_b_resp;

  always @(negedge clk) begin
    if (chk_en) begin
      if (r_valid) begin
        check("r_valid_expected", 64'(exp_r_pend), 64'd1);
        check("r_resp", 64'(r_resp), 64'(exp_r_resp));
        if (exp_r_known) check("r_data", r_data, exp_r_data);
      end
      if (b_valid) begin
        check("b_valid_expected", 64'(exp_b_pend), 64'd1);
        check("b_resp", 64'(b_resp), 64'(exp_b_resp));
      end
    end
  end

  // ---------------- transaction tasks (start and end at a negedge) ----------------
  task automatic do_read(input logic [63:0] addr, input int hold,
                         output logic [63:0] data, output int wait_cyc);
    int  n;
    bit  got;
    data = '0;
    ar_addr  = addr;
    ar_valid = 1'b1;
    #1;
    got = 1'b0;
    wait_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (ar_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
      wait_cyc++;
    end
    check("ar_accept", 64'(got), 64'd1);
    if (!got) begin
      ar_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ar_valid   = 1'b0;
    exp_r_resp = m_resp(addr);
    m_read(addr, exp_r_data, exp_r_known);
    exp_r_pend = 1'b1;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (r_valid) begin
        n = i;
        break;
      end
    end
    check("r_latency", 64'(n), 64'(LAT + 1));
    if (n == 0) begin
      exp_r_pend = 1'b0;
      return;
    end
    data = r_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("r_valid_hold", 64'(r_valid), 64'd1);
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready    = 1'b0;
    exp_r_pend = 1'b0;
    @(negedge clk);
    check("r_valid_drop", 64'(r_valid), 64'd0);
    check("idle_after_r", 64'(aw_ready), 64'd1);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int hold);
    int n;
    bit got;
    aw_addr  = addr;
    aw_valid = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (aw_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("aw_accept", 64'(got), 64'd1);
    if (!got) begin
      aw_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_data   = data;
    w_strb   = strb;
    w_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (w_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("w_accept", 64'(got), 64'd1);
    if (!got) begin
      w_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    m_write(addr, data, strb);
    exp_b_resp = m_resp(addr);
    exp_b_pend = 1'b1;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (b_valid) begin
        n = i;
        break;
      end
    end
    check("b_latency", 64'(n), 64'(LAT + 1));
    if (n == 0) begin
      exp_b_pend = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_valid_hold", 64'(b_valid), 64'd1);
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready    = 1'b0;
    exp_b_pend = 1'b0;
    @(negedge clk);
    check("b_valid_drop", 64'(b_valid), 64'd0);
    check("idle_after_b", 64'(aw_ready), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] got;
    int          wc;

    for (int i = 0; i < DEPTH; i++) mkb[i] = 8'h00;
    chk_en = 0; exp_r_pend = 0; exp_b_pend = 0; exp_r_known = 0;
    exp_r_data = '0; exp_r_resp = 2'b00; exp_b_resp = 2'b00;
    rst = 1'b1;
    ar_valid = 0; ar_addr = '0; r_ready = 0;
    aw_valid = 0; aw_addr = '0; w_valid = 0; w_strb = '0; w_data = '0; b_ready = 0;

    // Reset values (sampled while rst is still high)
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_r_valid",  64'(r_valid),  64'd0);
    check("rst_r_data",   r_data,        64'd0);
    check("rst_r_resp",   64'(r_resp),   64'd0);
    check("rst_w_ready",  64'(w_ready),  64'd0);
    check("rst_b_valid",  64'(b_valid),  64'd0);
    check("rst_b_resp",   64'(b_resp),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ar_ready", 64'(ar_ready), 64'd1);
    check("post_rst_aw_ready", 64'(aw_ready), 64'd1);
    chk_en = 1'b1;

    // First read: latency LAT+1 = 3, resp OKAY (data not yet defined)
    do_read(BASE, 0, got, wc);

    // Full write then partial strobe write, read back merged word
    do_write(BASE + 64'h10, 64'h1122334455667788, 8'hFF, 0);
    do_write(BASE + 64'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 2);
    do_read(BASE + 64'h10, 0, got, wc);
    check("strb_merge_literal", got, 64'h11223344_BBBBBBBB);

    // Sparse strobe pattern on another word
    do_write(BASE + 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    do_write(BASE + 64'h27, 64'h0000_0000_0000_0000, 8'h81, 0);
    do_read(BASE + 64'h20, 0, got, wc);
    check("strb_81_literal", got, 64'h00FF_FFFF_FFFF_FF00);

    // Simultaneous ar and aw: write wins, read accepted right after b handshake
    ar_addr  = BASE + 64'h18;
    ar_valid = 1'b1;
    aw_valid = 1'b1;
    aw_addr  = BASE + 64'h18;
    #1;
    check("both_ar_ready", 64'(ar_ready), 64'd0);
    check("both_aw_ready", 64'(aw_ready), 64'd1);
    do_write(BASE + 64'h18, 64'hDEADBEEF_01234567, 8'hFF, 1);
    do_read(BASE + 64'h18, 0, got, wc);
    check("ar_after_b_wait", 64'(wc), 64'd0);
    check("ar_after_b_data", got, 64'hDEADBEEF_01234567);

    // Backpressure: r_ready low for 5 cycles with r_valid high
    do_read(BASE + 64'h10, 5, got, wc);
    check("hold_data_literal", got, 64'h11223344_BBBBBBBB);

`ifdef YSYX_22050019_MEM_DECERR_EN
    // Below-range accesses: DECERR, zero data, write dropped
    do_write(BASE + 64'(1023 * 8), 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 0);
    do_read(64'h7FFF_FFF8, 0, got, wc);
    check("decerr_read_data", got, 64'd0);
    do_write(64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    do_read(BASE + 64'(1023 * 8), 0, got, wc);
    check("decerr_write_dropped", got, 64'h5A5A_5A5A_5A5A_5A5A);
`else
    // Beyond-range address aliases onto word 0
    do_write(BASE, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    do_read(BASE + 64'd8192, 0, got, wc);
    check("alias_word0", got, 64'h0123_4567_89AB_CDEF);
`endif

    // Reset while waiting for write data: write aborted, memory keeps old value
    aw_addr  = BASE + 64'h10;
    aw_valid = 1'b1;
    #1;
    check("abort_aw_ready", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    w_strb   = 8'hFF;
    @(negedge clk);
    check("abort_in_wdata", 64'(w_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_rst_w_ready",  64'(w_ready),  64'd0);
    check("abort_rst_aw_ready", 64'(aw_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(aw_ready), 64'd1);
    do_read(BASE + 64'h10, 0, got, wc);
    check("abort_old_data", got, 64'h11223344_BBBBBBBB);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
